// File: rtl/async_pkg.sv
// -----------------------------------------------------------------------------
// async_pkg
// Shared definitions for the async_master bus master and its phase counter.
//   BUS_W   : width of the shared tri-state data bus
//   state_t : transaction state encoding (IDLE=0 .. DONE=4, 3 bits)
// -----------------------------------------------------------------------------
package async_pkg;

  localparam int BUS_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/async_phase_cnt.sv
// -----------------------------------------------------------------------------
// async_phase_cnt
// Counts clk cycles spent in the current state of async_master and flags the
// last cycle of the phase.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   i_en     in   count enable (master not idle)
//   i_clear  in   state is changing on this edge; restart the phase at 0
//   i_last   in   counter value of the final cycle of the current phase
//   o_done   out  current cycle is the final cycle of the phase
// -----------------------------------------------------------------------------
module async_phase_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // Saturates instead of wrapping; in normal operation the state change
  // clears it long before the ceiling is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == i_last);

endmodule

// File: rtl/async_master.sv
// -----------------------------------------------------------------------------
// async_master
// Single-outstanding command master for a simple strobe/request slave bus.
// A command is accepted in IDLE, then the master walks START (1 cycle),
// WAIT (1 cycle), XFER (BAUD_TICKS+1 cycles, req high) and DONE (BAUD_TICKS
// cycles) before returning to IDLE with a one-cycle rsp_valid pulse.
// Accept-to-rsp_valid latency is 2*BAUD_TICKS+4 cycles.
//
// Parameters:
//   BAUD_TICKS  length of the DONE phase in cycles (1..8191)
// Ports:
//   clk        in    rising-edge clock
//   rst        in    asynchronous active-low reset
//   cmd_valid  in    command offered
//   cmd_ready  out   command accepted when high together with cmd_valid
//   cmd_rw     in    1 = write to slave, 0 = read from slave
//   cmd_wdata  in    write data
//   rsp_valid  out   one-cycle completion pulse
//   rsp_rdata  out   last read data, valid with rsp_valid, held otherwise
//   start      out   transaction-start strobe to the slave
//   rw         out   direction to the slave (0 while idle)
//   req        out   transfer request to the slave
//   data_bus   inout shared tri-state data bus
//   xfer_cnt   out   completed-transaction count (only with
//                    ASYNC_MASTER_STATS_EN defined)
// Build option: ASYNC_MASTER_STATS_EN adds the xfer_cnt statistics counter.
// -----------------------------------------------------------------------------
module async_master
  import async_pkg::*;
#(
  parameter int BAUD_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [BUS_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [BUS_W-1:0] rsp_rdata,
  output logic             start,
  output logic             rw,
  output logic             req,
  inout  wire  [BUS_W-1:0] data_bus
`ifdef ASYNC_MASTER_STATS_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam int CNT_W = $clog2(BAUD_TICKS + 2);
  localparam logic [CNT_W-1:0] LAST_XFER = CNT_W'(BAUD_TICKS);
  localparam logic [CNT_W-1:0] LAST_DONE = CNT_W'(BAUD_TICKS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_last;
  logic             w_done;
  logic             w_accept;
  logic             w_drive;
  logic             r_rw;
  logic [BUS_W-1:0] r_wdata;
  logic             r_rsp_valid;
  logic [BUS_W-1:0] r_rdata;

  // Holding off cmd_ready during the rsp_valid cycle guarantees the next
  // accept lands one cycle after the previous completion.
  assign cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;

  async_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state != S_IDLE),
    .i_clear (w_next != r_state),
    .i_last  (w_last),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // START and WAIT use a terminal count of 0, so they last exactly one cycle.
  always_comb begin
    w_next = r_state;
    w_last = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_START;
      end
      S_START: begin
        if (w_done) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done) w_next = S_XFER;
      end
      S_XFER: begin
        w_last = LAST_XFER;
        if (w_done) w_next = S_DONE;
      end
      S_DONE: begin
        w_last = LAST_DONE;
        if (w_done) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command fields are captured only on accept, so later changes on cmd_*
  // cannot disturb a transaction in flight. Their value is irrelevant while
  // idle because every use is gated by the state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rw    <= cmd_rw;
      r_wdata <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= (r_state == S_DONE) && w_done;
      if ((r_state == S_XFER) && w_done && !r_rw) begin
        r_rdata <= data_bus;
      end
    end
  end

  assign start     = (r_state == S_START);
  assign req       = (r_state == S_XFER);
  assign rw        = (r_state != S_IDLE) && r_rw;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

  assign w_drive  = (r_state == S_XFER) && r_rw;
  assign data_bus = w_drive ? r_wdata : {BUS_W{1'bz}};

`ifdef ASYNC_MASTER_STATS_EN
  logic [15:0] r_xfer_cnt;

  // Advances on the same edge that raises rsp_valid; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer_cnt <= '0;
    end else if ((r_state == S_DONE) && w_done) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_async_master.sv
// -----------------------------------------------------------------------------
// tb_async_master
// Directed bench for async_master with BAUD_TICKS=2 and a simple slave model.
// The driver pushes the expected completion (direction, write data, read
// data, completion cycle) into a scoreboard queue at accept time; a monitor
// process checks bus activity and pops/compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_async_master;

  localparam int BAUD = 2;
  localparam int LAT  = 8;   // 2*2+4
  localparam int REQN = 3;   // 2+1

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [3:0] cmd_wdata = 4'h0;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       start;
  logic       rw;
  logic       req;
  wire  [3:0] data_bus;
`ifdef ASYNC_MASTER_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  async_master #(
    .BAUD_TICKS (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .start     (start),
    .rw        (rw),
    .req       (req),
    .data_bus  (data_bus)
`ifdef ASYNC_MASTER_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: latches its read data on start, drives it while req is high
  // for a read, and captures the bus while req is high for a write.
  logic [3:0] slave_next = 4'h0;
  logic [3:0] slave_cur  = 4'h0;
  logic [3:0] slave_rx   = 4'h0;

  assign data_bus = (req && !rw) ? slave_cur : 4'bzzzz;

  always @(posedge clk) begin
    if (start) slave_cur <= slave_next;
    if (req && rw) slave_rx <= data_bus;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       rw;
    logic [3:0] wdata;
    logic [3:0] rdata;
    int         rsp_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_rdata = 4'h0;
  int         last_rsp_cyc = -100;

  // Monitor
  initial begin : monitor
    int   start_n;
    int   req_n;
    int   n_done;
    exp_t e;
    start_n = 0;
    req_n   = 0;
    n_done  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        start_n = 0;
        req_n   = 0;
        n_done  = 0;
      end else begin
        if (start) start_n++;
        if (req) begin
          req_n++;
          if (sb.size() == 0) begin
            chk("req_without_cmd", 32'd1, 32'd0);
          end else begin
            chk("rw_during_req", 32'(rw), 32'(sb[0].rw));
            if (sb[0].rw) chk("bus_write_data", 32'(data_bus), 32'(sb[0].wdata));
          end
        end
        if (rsp_valid) begin
          last_rsp_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_rsp_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            n_done++;
            chk("rsp_latency_cycle", 32'(cyc), 32'(e.rsp_cyc));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("start_pulse_cycles", 32'(start_n), 32'd1);
            chk("req_cycles", 32'(req_n), 32'(REQN));
            if (e.rw) chk("slave_rx_data", 32'(slave_rx), 32'(e.wdata));
`ifdef ASYNC_MASTER_STATS_EN
            chk("xfer_cnt", 32'(xfer_cnt), 32'(n_done));
`endif
          end
          start_n = 0;
          req_n   = 0;
        end
      end
    end
  end

  // Offer a command at a negedge, wait (bounded) for acceptance, push the
  // expected completion, then scramble cmd_* once the slave has latched.
  task automatic issue(input logic rw_i, input logic [3:0] wd, input logic [3:0] sd,
                       input bit keep, input bit b2b);
    exp_t e;
    bit   acc;
    acc        = 1'b0;
    slave_next = sd;
    cmd_valid  = 1'b1;
    cmd_rw     = rw_i;
    cmd_wdata  = wd;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_gap", 32'(cyc), 32'(last_rsp_cyc + 1));
    if (!rw_i) model_rdata = sd;
    e.rw      = rw_i;
    e.wdata   = wd;
    e.rdata   = model_rdata;
    e.rsp_cyc = cyc + LAT;
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    cmd_rw    = ~rw_i;
    cmd_wdata = ~wd;
    if (!keep) cmd_valid = 1'b0;
  endtask

  initial begin : stimulus
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_start", 32'(start), 32'd0);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_rw", 32'(rw), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Write, read, write (read data must hold through the write)
    issue(1'b1, 4'hA, 4'h0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    issue(1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    issue(1'b1, 4'h3, 4'h0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // Back-to-back with cmd_valid held high
    issue(1'b1, 4'hC, 4'h0, 1'b1, 1'b0);
    issue(1'b0, 4'h0, 4'h9, 1'b1, 1'b1);
    issue(1'b1, 4'h6, 4'h0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Reset during XFER aborts the transaction
    issue(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !req; i++) @(negedge clk);
    chk("reached_xfer", 32'(req), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_start", 32'(start), 32'd0);
    chk("abort_req", 32'(req), 32'd0);
    chk("abort_rw", 32'(rw), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
    sb.delete();
    model_rdata = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_abort", 32'(cmd_ready), 32'd1);
    repeat (12) @(negedge clk);

    // Normal operation after the abort
    issue(1'b0, 4'h0, 4'h7, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    issue(1'b1, 4'h2, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
